// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit for the multi-cycle RISC-V core.
// Owns the PC and instruction register, runs demand fetches against a
// variable-latency instruction memory (req/ack with timeout) and exposes
// the decoded instruction fields to the control unit.
// Optional feature macro: IF_PREFETCH_EN builds a one-entry prefetch buffer
// that is filled after every completed fetch to hide memory latency.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IR_Write,
   input  logic        PC_Write,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   output logic [31:0] pc,
   output logic [31:0] ir,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rd,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic        if_busy,
   output logic        if_err
);

   localparam int          TW    = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [31:0] NOP   = 32'h0000_0013;

   localparam logic [1:0]  IDLE  = 2'd0;
   localparam logic [1:0]  FETCH = 2'd1;
`ifdef IF_PREFETCH_EN
   localparam logic [1:0]  PREF  = 2'd2;
`endif

   logic [1:0]    state, state_nxt;
   logic [TW-1:0] tcnt, tcnt_nxt;
   logic          pc_inc, pc_inc_nxt;
   logic          req_nxt, busy_nxt, err_nxt;
   logic [31:0]   addr_nxt, pc_nxt, ir_nxt;
   logic [31:0]   pc_plus4;
   logic          timed_out;
`ifdef IF_PREFETCH_EN
   logic          pf_valid, pf_valid_nxt;
   logic [31:0]   pf_addr, pf_addr_nxt;
   logic [31:0]   pf_data, pf_data_nxt;
`endif

   assign opcode = ir[6:0];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];
   assign rd     = ir[11:7];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];

   assign pc_plus4  = pc + 32'd4;
   assign timed_out = imem_req && !imem_ack && (tcnt == TLAST);

   // Next-state decision: trigger handling, ack completion and timeout for
   // whichever access (demand or prefetch) is currently outstanding.
   always_comb begin
      state_nxt  = state;
      tcnt_nxt   = tcnt;
      pc_inc_nxt = pc_inc;
      req_nxt    = imem_req;
      addr_nxt   = imem_addr;
      busy_nxt   = if_busy;
      err_nxt    = if_err;
      pc_nxt     = pc;
      ir_nxt     = ir;
`ifdef IF_PREFETCH_EN
      pf_valid_nxt = pf_valid;
      pf_addr_nxt  = pf_addr;
      pf_data_nxt  = pf_data;
`endif
      case (state)
         IDLE: begin
            if (IR_Write) begin
`ifdef IF_PREFETCH_EN
               pf_valid_nxt = 1'b0;
               if (pf_valid && (pf_addr == pc)) begin
                  ir_nxt    = pf_data;
                  pc_nxt    = PC_Write ? pc_plus4 : pc;
                  state_nxt = PREF;
                  req_nxt   = 1'b1;
                  addr_nxt  = pc_nxt;
                  tcnt_nxt  = '0;
               end else begin
`endif
                  state_nxt  = FETCH;
                  req_nxt    = 1'b1;
                  addr_nxt   = pc;
                  busy_nxt   = 1'b1;
                  tcnt_nxt   = '0;
                  pc_inc_nxt = PC_Write;
`ifdef IF_PREFETCH_EN
               end
`endif
            end
         end
         FETCH: begin
            if (imem_ack) begin
               ir_nxt   = imem_rdata;
               pc_nxt   = pc_inc ? pc_plus4 : pc;
               busy_nxt = 1'b0;
               tcnt_nxt = '0;
`ifdef IF_PREFETCH_EN
               state_nxt = PREF;
               addr_nxt  = pc_nxt;
`else
               state_nxt = IDLE;
               req_nxt   = 1'b0;
`endif
            end else if (timed_out) begin
               ir_nxt    = NOP;
               err_nxt   = 1'b1;
               state_nxt = IDLE;
               req_nxt   = 1'b0;
               busy_nxt  = 1'b0;
               tcnt_nxt  = '0;
            end else begin
               tcnt_nxt = tcnt + TW'(1);
            end
         end
`ifdef IF_PREFETCH_EN
         PREF: begin
            if (imem_ack) begin
               tcnt_nxt = '0;
               if (IR_Write) begin
                  ir_nxt   = imem_rdata;
                  pc_nxt   = PC_Write ? pc_plus4 : pc;
                  addr_nxt = pc_nxt;
               end else begin
                  pf_data_nxt  = imem_rdata;
                  pf_addr_nxt  = imem_addr;
                  pf_valid_nxt = 1'b1;
                  state_nxt    = IDLE;
                  req_nxt      = 1'b0;
               end
            end else if (timed_out) begin
               pf_valid_nxt = 1'b0;
               tcnt_nxt     = '0;
               if (IR_Write) begin
                  state_nxt  = FETCH;
                  addr_nxt   = pc;
                  busy_nxt   = 1'b1;
                  pc_inc_nxt = PC_Write;
               end else begin
                  state_nxt = IDLE;
                  req_nxt   = 1'b0;
               end
            end else begin
               tcnt_nxt = tcnt + TW'(1);
               if (IR_Write) begin
                  state_nxt  = FETCH;
                  busy_nxt   = 1'b1;
                  pc_inc_nxt = PC_Write;
               end
            end
         end
`endif
         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            busy_nxt  = 1'b0;
            tcnt_nxt  = '0;
         end
      endcase
   end

   // State and output registers; reset abandons any in-flight request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tcnt      <= '0;
         pc_inc    <= 1'b0;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         if_busy   <= 1'b0;
         if_err    <= 1'b0;
         pc        <= RESET_PC;
         ir        <= NOP;
      end else begin
         state     <= state_nxt;
         tcnt      <= tcnt_nxt;
         pc_inc    <= pc_inc_nxt;
         imem_req  <= req_nxt;
         imem_addr <= addr_nxt;
         if_busy   <= busy_nxt;
         if_err    <= err_nxt;
         pc        <= pc_nxt;
         ir        <= ir_nxt;
      end
   end

`ifdef IF_PREFETCH_EN
   // Prefetch buffer registers; only the valid flag needs a reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         pf_valid <= 1'b0;
         pf_addr  <= RESET_PC;
         pf_data  <= NOP;
      end else begin
         pf_valid <= pf_valid_nxt;
         pf_addr  <= pf_addr_nxt;
         pf_data  <= pf_data_nxt;
      end
   end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch.
// Directed vector tables cover the fetch, prefetch and timeout scenarios;
// a transaction-level reference model checks every cycle of a random run.
module tb_inst_fetch;

`ifdef IF_PREFETCH_EN
   localparam bit PF_EN = 1'b1;
`else
   localparam bit PF_EN = 1'b0;
`endif
   localparam int          TMO    = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, IR_Write, PC_Write, imem_ack;
   logic [31:0] imem_rdata;
   logic        imem_req, if_busy, if_err;
   logic [31:0] imem_addr, pc, ir;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd, rs1, rs2;

   logic        w_req, w_busy, w_err;
   logic [31:0] w_addr, w_pc, w_ir;
   logic [6:0]  w_opcode, w_funct7;
   logic [2:0]  w_funct3;
   logic [4:0]  w_rd, w_rs1, w_rs2;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .IR_Write(IR_Write), .PC_Write(PC_Write),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .ir(ir),
      .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .rd(rd), .rs1(rs1), .rs2(rs2), .if_busy(if_busy), .if_err(if_err)
   );

   // Second instance starting at the top of the address space for PC wrap.
   inst_fetch #(.RESET_PC(WRAP_PC), .TIMEOUT(TMO)) dut_wrap (
      .clk(clk), .rst(rst), .IR_Write(IR_Write), .PC_Write(PC_Write),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .imem_req(w_req), .imem_addr(w_addr), .pc(w_pc), .ir(w_ir),
      .opcode(w_opcode), .funct3(w_funct3), .funct7(w_funct7),
      .rd(w_rd), .rs1(w_rs1), .rs2(w_rs2), .if_busy(w_busy), .if_err(w_err)
   );

   // Reference model: one outstanding transaction record plus a queue
   // holding at most one prefetched {address, data} pair.
   typedef struct { logic [31:0] addr; logic [31:0] data; } pf_entry_t;
   pf_entry_t   pf_q[$];
   logic [31:0] m_pc, m_ir, m_addr;
   bit          m_err, m_active, m_demand, m_pcinc;
   int          m_age;

   typedef struct {
      bit trig; bit pcw; bit ack; logic [31:0] rdata;
      bit e_req; logic [31:0] e_addr; bit e_busy;
      logic [31:0] e_ir; logic [31:0] e_pc; bit e_err;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(bit t, bit p, bit a, logic [31:0] d, bit er,
                               logic [31:0] ea, bit eb, logic [31:0] ei,
                               logic [31:0] ep, bit ee);
      vec_t v;
      v.trig = t; v.pcw = p; v.ack = a; v.rdata = d;
      v.e_req = er; v.e_addr = ea; v.e_busy = eb;
      v.e_ir = ei; v.e_pc = ep; v.e_err = ee;
      return v;
   endfunction

   task automatic modelReset();
      m_pc = RST_PC; m_ir = NOP; m_addr = RST_PC; m_err = 0;
      m_active = 0; m_demand = 0; m_pcinc = 0; m_age = 0;
      pf_q.delete();
   endtask

   task automatic startReq(input bit demand, input bit pcinc);
      m_active = 1; m_demand = demand; m_pcinc = pcinc;
      m_addr = m_pc; m_age = 0;
   endtask

   task automatic modelStep(input bit trig, input bit pcw, input bit ack,
                            input logic [31:0] rdata);
      if (!m_active) begin
         if (trig) begin
            if (pf_q.size() > 0 && pf_q[0].addr == m_pc) begin
               m_ir = pf_q[0].data;
               if (pcw) m_pc = m_pc + 32'd4;
               pf_q.delete();
               startReq(0, 0);
            end else begin
               pf_q.delete();
               startReq(1, pcw);
            end
         end
      end else if (ack) begin
         if (m_demand) begin
            m_ir = rdata;
            if (m_pcinc) m_pc = m_pc + 32'd4;
            if (PF_EN) startReq(0, 0);
            else m_active = 0;
         end else if (trig) begin
            m_ir = rdata;
            if (pcw) m_pc = m_pc + 32'd4;
            startReq(0, 0);
         end else begin
            pf_q.push_back('{addr: m_addr, data: rdata});
            m_active = 0;
         end
      end else begin
         m_age++;
         if (m_age == TMO) begin
            m_active = 0;
            if (m_demand) begin
               m_ir = NOP;
               m_err = 1;
            end else if (trig) begin
               startReq(1, pcw);
            end
         end else if (!m_demand && trig) begin
            m_demand = 1;
            m_pcinc  = pcw;
         end
      end
   endtask

   task automatic checkOne(input string tag, input string name,
                           input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s %s: got %h expected %h", tag, name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne(tag, "imem_req", imem_req, m_active);
      checkOne(tag, "imem_addr", imem_addr, m_addr);
      checkOne(tag, "if_busy", if_busy, m_active && m_demand);
      checkOne(tag, "ir", ir, m_ir);
      checkOne(tag, "pc", pc, m_pc);
      checkOne(tag, "if_err", if_err, m_err);
      checkOne(tag, "opcode", opcode, m_ir[6:0]);
      checkOne(tag, "funct3", funct3, m_ir[14:12]);
      checkOne(tag, "funct7", funct7, m_ir[31:25]);
      checkOne(tag, "rd", rd, m_ir[11:7]);
      checkOne(tag, "rs1", rs1, m_ir[19:15]);
      checkOne(tag, "rs2", rs2, m_ir[24:20]);
   endtask

   task automatic applyStimulus(input bit r, input bit trig, input bit pcw,
                                input bit ack, input logic [31:0] rdata,
                                input string tag);
      rst = r; IR_Write = trig; PC_Write = pcw;
      imem_ack = ack; imem_rdata = rdata;
      @(posedge clk);
      if (r) modelReset();
      else modelStep(trig, pcw, ack, rdata);
      #1;
      checkOutput(tag);
   endtask

   task automatic checkTable(input vec_t v, input string tag);
      checkOne(tag, "tbl_req", imem_req, v.e_req);
      checkOne(tag, "tbl_addr", imem_addr, v.e_addr);
      checkOne(tag, "tbl_busy", if_busy, v.e_busy);
      checkOne(tag, "tbl_ir", ir, v.e_ir);
      checkOne(tag, "tbl_pc", pc, v.e_pc);
      checkOne(tag, "tbl_err", if_err, v.e_err);
      checkOne(tag, "tbl_funct7", funct7, v.e_ir[31:25]);
      checkOne(tag, "tbl_rs2", rs2, v.e_ir[24:20]);
      checkOne(tag, "tbl_rs1", rs1, v.e_ir[19:15]);
      checkOne(tag, "tbl_rd", rd, v.e_ir[11:7]);
      checkOne(tag, "tbl_opcode", opcode, v.e_ir[6:0]);
   endtask

   initial begin
      // Directed sequences: miss with 3-cycle ack, then prefetch or timeout.
      vecs.push_back(mk(1, 1, 0, 32'h0, 1, 32'h0, 1, NOP, 32'h0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0, 1, 32'h0, 1, NOP, 32'h0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0, 1, 32'h0, 1, NOP, 32'h0, 0));
`ifdef IF_PREFETCH_EN
      vecs.push_back(mk(0, 0, 1, 32'h00500093, 1, 32'h4, 0, 32'h00500093, 32'h4, 0));
      vecs.push_back(mk(0, 0, 1, 32'h00A00113, 0, 32'h4, 0, 32'h00500093, 32'h4, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0, 1, 32'h8, 0, 32'h00A00113, 32'h8, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0, 1, 32'h8, 1, 32'h00A00113, 32'h8, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0, 1, 32'h8, 1, 32'h00A00113, 32'h8, 0));
      vecs.push_back(mk(0, 0, 1, 32'h002081B3, 1, 32'hC, 0, 32'h002081B3, 32'hC, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 32'h0, 1, 32'hC, 0, 32'h002081B3, 32'hC, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0, 0, 32'hC, 0, 32'h002081B3, 32'hC, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0, 1, 32'hC, 1, 32'h002081B3, 32'hC, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 32'h0, 1, 32'hC, 1, 32'h002081B3, 32'hC, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0, 0, 32'hC, 0, NOP, 32'hC, 1));
      vecs.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 32'hC, 0, NOP, 32'hC, 1));
`else
      vecs.push_back(mk(0, 0, 1, 32'h00500093, 0, 32'h0, 0, 32'h00500093, 32'h4, 0));
      vecs.push_back(mk(1, 1, 0, 32'h0, 1, 32'h4, 1, 32'h00500093, 32'h4, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(0, 0, 0, 32'h0, 1, 32'h4, 1, 32'h00500093, 32'h4, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0, 0, 32'h4, 0, NOP, 32'h4, 1));
      vecs.push_back(mk(0, 0, 1, 32'hDEADBEEF, 0, 32'h4, 0, NOP, 32'h4, 1));
`endif

      $display("[TB] reset check");
      applyStimulus(1, 0, 0, 0, 32'h0, "reset");
      checkOne("reset", "pc_const", pc, RST_PC);
      checkOne("reset", "ir_const", ir, NOP);
      checkOne("reset", "req_const", imem_req, 1'b0);
      checkOne("reset", "busy_const", if_busy, 1'b0);
      checkOne("reset", "err_const", if_err, 1'b0);
      checkOne("reset", "wrap_pc", w_pc, WRAP_PC);

      $display("[TB] directed vector table (%0d entries)", vecs.size());
      foreach (vecs[i]) begin
         applyStimulus(0, vecs[i].trig, vecs[i].pcw, vecs[i].ack,
                       vecs[i].rdata, $sformatf("vec%0d", i));
         checkTable(vecs[i], $sformatf("vec%0d", i));
         if (i == 3) begin
            checkOne("vec3", "wrap_pc", w_pc, 32'h0);
            checkOne("vec3", "wrap_ir", w_ir, 32'h00500093);
         end
      end

      $display("[TB] reset during demand fetch");
      applyStimulus(1, 0, 0, 0, 32'h0, "rst_pre");
      applyStimulus(0, 1, 1, 0, 32'h0, "rst_trig");
      applyStimulus(0, 0, 0, 0, 32'h0, "rst_fetch1");
      applyStimulus(1, 0, 0, 1, 32'h12345678, "rst_mid");
      checkOne("rst_mid", "req_const", imem_req, 1'b0);
      checkOne("rst_mid", "pc_const", pc, RST_PC);
      checkOne("rst_mid", "busy_const", if_busy, 1'b0);
      applyStimulus(0, 1, 1, 0, 32'h0, "rst_after");
      checkOne("rst_after", "busy_const", if_busy, 1'b1);
      checkOne("rst_after", "addr_const", imem_addr, RST_PC);

      $display("[TB] random run against reference model");
      for (int n = 0; n < 3000; n++) begin
         applyStimulus($urandom_range(0, 199) == 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) == 0,
                       $urandom, "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
